titan_mem_arbiter: RTL

Shares the single external memory bus between the instruction-fetch port (IF stage) and the data port (MEM stage) of the Titan pipeline. Performs round-robin arbitration on a registered grant, multiplexes the Wishbone-style request onto the shared bus, and routes ack/err back to the granted requester only. A per-transaction timeout converts a hung bus cycle into an error response, which the trap logic reports as an access fault.

---
 rtl/titan_arb_pkg.sv | 29 ++
 rtl/titan_arb_timeout.sv | 33 +++
 rtl/titan_mem_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/titan_arb_pkg.sv
// Shared types and helpers for the Titan memory-bus arbiter.
package titan_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_e;

  // Counter width for a timeout limit; a disabled timeout (0) still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit > 0) ? $clog2(limit + 1) : 1;
  endfunction

  // Round-robin pick: on a tie the port that did not complete last wins.
  function automatic arb_state_e pick_grant(input logic req_i, input logic req_d,
                                            input gnt_e last);
    if (req_i && req_d) return (last == GNT_I) ? GRANT_D : GRANT_I;
    if (req_i)          return GRANT_I;
    if (req_d)          return GRANT_D;
    return IDLE;
  endfunction

endpackage

// File: rtl/titan_arb_timeout.sv
// Per-transaction watchdog: counts stalled granted cycles and flags expiry.
module titan_arb_timeout
  import titan_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned         CNT_W   = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]    LIMIT   = CNT_W'(TIMEOUT_CYCLES);
  localparam bit                  ENABLED = (TIMEOUT_CYCLES != 0);

  logic [CNT_W-1:0] r_count;

  // Count stalled cycles of the current transaction; holds at the limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (ENABLED && i_enable && (r_count != LIMIT)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_expired = ENABLED && (r_count == LIMIT);

endmodule

// File: rtl/titan_mem_arbiter.sv
// Round-robin arbiter sharing one Wishbone-style bus between fetch and data ports.
module titan_mem_arbiter
  import titan_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] iport_addr,
  input  logic        iport_cyc,
  input  logic        iport_stb,
  output logic [31:0] iport_data_o,
  output logic        iport_ack,
  output logic        iport_err,
  input  logic [31:0] dport_addr,
  input  logic [31:0] dport_data_i,
  input  logic [3:0]  dport_sel,
  input  logic        dport_we,
  input  logic        dport_cyc,
  input  logic        dport_stb,
  output logic [31:0] dport_data_o,
  output logic        dport_ack,
  output logic        dport_err,
  output logic [31:0] xport_addr,
  output logic [31:0] xport_data_o,
  output logic [3:0]  xport_sel,
  output logic        xport_we,
  output logic        xport_cyc,
  output logic        xport_stb,
  input  logic [31:0] xport_data_i,
  input  logic        xport_ack,
  input  logic        xport_err
);

  arb_state_e r_state, w_state_nxt;
  gnt_e       r_last, w_last_nxt;

  logic w_req_i, w_req_d;
  logic w_granted, w_expired, w_done, w_abort;
  logic w_tmo_clear, w_tmo_enable;
  logic w_resp_ack, w_resp_err;

  assign w_req_i   = iport_cyc & iport_stb;
  assign w_req_d   = dport_cyc & dport_stb;
  assign w_granted = (r_state != IDLE);

  // A transaction ends on a bus response or on the watchdog firing.
  assign w_done  = w_granted & (xport_ack | xport_err | w_expired);
  assign w_abort = ((r_state == GRANT_I) & ~iport_cyc) |
                   ((r_state == GRANT_D) & ~dport_cyc);

  // The watchdog restarts whenever a new grant can begin.
  assign w_tmo_clear  = (r_state == IDLE) | w_done | w_abort;
  assign w_tmo_enable = w_granted & ~xport_ack & ~xport_err;

  titan_arb_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_tmo_clear),
    .i_enable  (w_tmo_enable),
    .o_expired (w_expired)
  );

  // Grant and round-robin history registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_last  <= GNT_I;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Next grant: completion hands straight over to the other port if it waits.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    case (r_state)
      IDLE: begin
        w_state_nxt = pick_grant(w_req_i, w_req_d, r_last);
      end
      GRANT_I: begin
        if (w_done) begin
          w_last_nxt  = GNT_I;
          w_state_nxt = pick_grant(1'b0, w_req_d, GNT_I);
        end else if (!iport_cyc) begin
          w_state_nxt = IDLE;
        end
      end
      GRANT_D: begin
        if (w_done) begin
          w_last_nxt  = GNT_D;
          w_state_nxt = pick_grant(w_req_i, 1'b0, GNT_D);
        end else if (!dport_cyc) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Drive the shared bus from the granted port; cyc/stb drop on expiry.
  always_comb begin
    xport_addr   = '0;
    xport_data_o = '0;
    xport_sel    = '0;
    xport_we     = 1'b0;
    xport_cyc    = 1'b0;
    xport_stb    = 1'b0;
    case (r_state)
      GRANT_I: begin
        xport_addr = iport_addr;
        xport_sel  = 4'hF;
        xport_cyc  = iport_cyc & ~w_expired;
        xport_stb  = iport_stb & ~w_expired;
      end
      GRANT_D: begin
        xport_addr   = dport_addr;
        xport_data_o = dport_data_i;
        xport_sel    = dport_sel;
        xport_we     = dport_we;
        xport_cyc    = dport_cyc & ~w_expired;
        xport_stb    = dport_stb & ~w_expired;
      end
      default: begin
      end
    endcase
  end

  // Error dominates ack; a watchdog expiry is reported as an error.
  assign w_resp_err = xport_err | w_expired;
  assign w_resp_ack = xport_ack & ~xport_err & ~w_expired;

  // Return the response only to the port that owns the bus.
  always_comb begin
    iport_ack = 1'b0;
    iport_err = 1'b0;
    dport_ack = 1'b0;
    dport_err = 1'b0;
    if (r_state == GRANT_I) begin
      iport_ack = w_resp_ack;
      iport_err = w_resp_err;
    end else if (r_state == GRANT_D) begin
      dport_ack = w_resp_ack;
      dport_err = w_resp_err;
    end
  end

  assign iport_data_o = xport_data_i;
  assign dport_data_o = xport_data_i;

endmodule
